// File: rtl/nv_dw_lsd_denorm.sv
// nv_dw_lsd_denorm: iterative leading-sign-digit de-normaliser.
// Takes a left-normalised two's-complement value plus its sign-bit count and
// restores the original magnitude by an arithmetic right shift. The shift
// consumes at most SHIFT_STEP bits per cycle.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. Once out_pvld rises, it and out_data stay
// stable until out_prdy is seen high. in_data/in_enc are sampled only on a
// transfer.
//
// Optional build macro: NV_DW_LSD_DENORM_ROUND_EN
//   defined   - out_data is rounded half-up using the last bit shifted out.
//   undefined - out_data is truncated toward -inf. The round bit is not built.
module nv_dw_lsd_denorm #(
    parameter int a_width    = 8,
    parameter int SHIFT_STEP = 2,
    localparam int enc_width = (a_width <= 2)   ? 1 :
                               (a_width <= 4)   ? 2 :
                               (a_width <= 8)   ? 3 :
                               (a_width <= 16)  ? 4 :
                               (a_width <= 32)  ? 5 :
                               (a_width <= 64)  ? 6 :
                               (a_width <= 128) ? 7 : 8
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 in_pvld,
    output logic                 in_prdy,
    input  logic [a_width-1:0]   in_data,
    input  logic [enc_width-1:0] in_enc,
    output logic                 out_pvld,
    input  logic                 out_prdy,
    output logic [a_width-1:0]   out_data
);

    localparam logic [enc_width-1:0] MAX_ENC = enc_width'(a_width - 1);
    localparam logic [enc_width-1:0] STEP    = enc_width'(SHIFT_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [a_width-1:0]   acc_q,   acc_d;
    logic [enc_width-1:0] cnt_q,   cnt_d;
    logic [enc_width-1:0] enc_clamp;
    logic [enc_width-1:0] step_s;
    logic [31:0]          enc_ext;
    logic                 accept;
`ifdef NV_DW_LSD_DENORM_ROUND_EN
    logic                 rnd_q,   rnd_d;
    logic [enc_width-1:0] last_idx;
    logic                 last_bit;
`endif

    // Shift amount is clamped so the value is never shifted past its sign bit;
    // each cycle moves at most SHIFT_STEP bits.
    always_comb begin
        enc_ext   = 32'(in_enc);
        enc_clamp = (enc_ext > 32'(a_width - 1)) ? MAX_ENC : in_enc;
        step_s    = (cnt_q < STEP) ? cnt_q : STEP;
        accept    = in_pvld & in_prdy;
`ifdef NV_DW_LSD_DENORM_ROUND_EN
        last_idx  = step_s - enc_width'(1);
        last_bit  = acc_q[last_idx];
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef NV_DW_LSD_DENORM_ROUND_EN
            rnd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef NV_DW_LSD_DENORM_ROUND_EN
            rnd_q   <= rnd_d;
`endif
        end
    end

    // Next state: load on accept, shift while count remains, retire in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef NV_DW_LSD_DENORM_ROUND_EN
        rnd_d   = rnd_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    acc_d   = in_data;
                    cnt_d   = enc_clamp;
`ifdef NV_DW_LSD_DENORM_ROUND_EN
                    rnd_d   = 1'b0;
`endif
                    state_d = (enc_clamp == '0) ? DONE : SHIFT;
                end else if (state_q == DONE && out_prdy) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = $unsigned($signed(acc_q) >>> step_s);
                cnt_d = cnt_q - step_s;
`ifdef NV_DW_LSD_DENORM_ROUND_EN
                rnd_d = last_bit;
`endif
                if (cnt_q == step_s) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: ready in IDLE, or in DONE when the result retires this cycle.
    always_comb begin
        out_pvld = (state_q == DONE);
        in_prdy  = ~nvdla_core_rst &
                   ((state_q == IDLE) | ((state_q == DONE) & out_prdy));
`ifdef NV_DW_LSD_DENORM_ROUND_EN
        out_data = acc_q + {{(a_width-1){1'b0}}, rnd_q};
`else
        out_data = acc_q;
`endif
    end

endmodule

// File: tb/tb_nv_dw_lsd_denorm.sv
// Bench for nv_dw_lsd_denorm (a_width=8, SHIFT_STEP=2). Expected results
// come from a floor-division model of the arithmetic shift; a scoreboard
// queue holds expected data and expected presentation cycles, and a monitor
// pops them whenever the DUT presents or retires an output.
module tb_nv_dw_lsd_denorm;

    logic       clk;
    logic       rst;
    logic       in_pvld;
    logic       in_prdy;
    logic [7:0] in_data;
    logic [2:0] in_enc;
    logic       out_pvld;
    logic       out_prdy;
    logic [7:0] out_data;

    int         cyc;
    int         checks;
    int         failures;
    logic [7:0] exp_q[$];
    int         due_q[$];
    bit         rand_prdy;
    bit         last_acc_pvld;

    nv_dw_lsd_denorm #(.a_width(8), .SHIFT_STEP(2)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_pvld        (in_pvld),
        .in_prdy        (in_prdy),
        .in_data        (in_data),
        .in_enc         (in_enc),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_data       (out_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Value divided by 2^sh with floor; rounding adds half an LSB first.
    function automatic logic [7:0] ref_out(logic [7:0] d, int e);
        int sh;
        int v;
        int p;
        int num;
        int den;
        int q;
        sh = (e > 7) ? 7 : e;
        v  = int'($signed(d));
        p  = 1 << sh;
`ifdef NV_DW_LSD_DENORM_ROUND_EN
        num = 2 * v + p;
        den = 2 * p;
`else
        num = v;
        den = p;
`endif
        q = (num >= 0) ? (num / den) : -((-num + den - 1) / den);
        return q[7:0];
    endfunction

    function automatic int ref_lat(int e);
        int sh;
        sh = (e > 7) ? 7 : e;
        return 1 + (sh + 1) / 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [2:0] e);
        bit acc;
        acc     = 1'b0;
        in_pvld = 1'b1;
        in_data = d;
        in_enc  = e;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (in_prdy) begin
                acc           = 1'b1;
                last_acc_pvld = out_pvld;
                exp_q.push_back(ref_out(d, int'(e)));
                due_q.push_back(cyc + ref_lat(int'(e)));
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_prdy stayed 0, required 1 (cycle %0d)", cyc);
        end
        @(negedge clk);
        in_pvld = 1'b0;
    endtask

    task automatic wait_pvld();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_pvld) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL pvld_timeout: out_pvld stayed 0, required 1 (cycle %0d)", cyc);
        end
    endtask

    // Random output back-pressure when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_prdy) out_prdy = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit         fresh;
        bit         prev_stall;
        logic [7:0] held;
        fresh      = 1'b1;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                fresh      = 1'b1;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_pvld", 32'(out_pvld), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(held));
                end
                if (out_pvld && !out_prdy) chk("stall_in_prdy", 32'(in_prdy), 32'd0);
                if (out_pvld && fresh) begin
                    if (due_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL latency: output with no pending input, data %0h", out_data);
                    end else begin
                        chk("latency_cycle", 32'(cyc), 32'(due_q.pop_front()));
                    end
                    fresh = 1'b0;
                end
                if (out_pvld && out_prdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_data: unexpected output %0h, none required", out_data);
                    end else begin
                        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                    fresh = 1'b1;
                end
                prev_stall = out_pvld & ~out_prdy;
                held       = out_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit drained;
        checks        = 0;
        failures      = 0;
        rand_prdy     = 1'b0;
        last_acc_pvld = 1'b0;
        rst           = 1'b1;
        in_pvld       = 1'b0;
        in_data       = '0;
        in_enc        = '0;
        out_prdy      = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_out_pvld", 32'(out_pvld), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_prdy",  32'(in_prdy),  32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_prdy", 32'(in_prdy), 32'd1);
        @(negedge clk);

        // Directed values, output always ready.
        out_prdy = 1'b1;
        send(8'hA0, 3'd3);
        send(8'h5A, 3'd0);
        send(8'h40, 3'd7);
        send(8'h80, 3'd7);
        send(8'h6C, 3'd3);
        send(8'h7F, 3'd1);
        send(8'h5A, 3'd0);
        send(8'h01, 3'd0);

        // Back-pressure in DONE, then retire and accept in one cycle.
        repeat (10) @(negedge clk);
        out_prdy = 1'b0;
        send(8'h33, 3'd2);
        wait_pvld();
        repeat (5) @(negedge clk);
        out_prdy = 1'b1;
        send(8'hC3, 3'd1);
        chk("retire_accept_same_cycle", 32'(last_acc_pvld), 32'd1);
        repeat (10) @(negedge clk);

        // Reset while shifting discards the transaction.
        send(8'h80, 3'd7);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_pvld", 32'(out_pvld), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_in_prdy",  32'(in_prdy),  32'd0);
        exp_q.delete();
        due_q.delete();
        rst = 1'b0;
        #1;
        chk("midrst_release_in_prdy", 32'(in_prdy), 32'd1);
        @(negedge clk);
        send(8'h80, 3'd1);
        repeat (5) @(negedge clk);

        // Random traffic with random back-pressure.
        rand_prdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        end

        // Drain.
        @(negedge clk);
        rand_prdy = 1'b0;
        out_prdy  = 1'b1;
        drained   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        chk("drain_complete", 32'(drained), 32'd1);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
